// File: rtl/mmio_pkg.sv
// Shared types and default address map for the MMIO interconnect.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam int DEF_NUM_SLAVES = 4;

  // Slave k occupies bits [k*32 +: 32].
  localparam logic [DEF_NUM_SLAVES*32-1:0] DEF_REGION_BASE = {
    32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000
  };
  localparam logic [DEF_NUM_SLAVES*32-1:0] DEF_REGION_MASK = {DEF_NUM_SLAVES{32'hFFFF_F000}};

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_region_decoder.sv
// Combinational priority address decoder; the lowest matching slave index wins.
module mmio_region_decoder
  import mmio_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
  parameter int IDX_W = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  // Scanning downward lets the lowest matching index overwrite higher ones.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((addr & REGION_MASK[k*ADDR_W +: ADDR_W]) == REGION_BASE[k*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/mmio_interconnect.sv
// Single-outstanding MMIO interconnect: IDLE -> ACCESS -> RESP, one slave at a time.
// Optional access timeout enabled by defining MMIO_TIMEOUT_EN.
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic                         req_we,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic                         s_we,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata
);

  localparam int IDX_W = idx_width(NUM_SLAVES);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sel_idx;
  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic             accept;
  logic             sel_ready;
  logic             tmo_hit;

  mmio_region_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .REGION_BASE(REGION_BASE),
    .REGION_MASK(REGION_MASK),
    .IDX_W      (IDX_W)
  ) u_decoder (
    .addr(req_addr),
    .hit (dec_hit),
    .idx (dec_idx)
  );

  assign accept    = req_valid && (state == ST_IDLE);
  assign sel_ready = s_ready[sel_idx];

`ifdef MMIO_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Fires in the TIMEOUT_CYCLES-th ACCESS cycle if the slave is still silent.
  assign tmo_hit = !sel_ready && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (accept) begin
      tmo_cnt <= '0;
    end else if (state == ST_ACCESS) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_valid) state_nxt = dec_hit ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (sel_ready || tmo_hit) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  always_comb begin
    s_sel = '0;
    if (state == ST_ACCESS) s_sel[sel_idx] = 1'b1;
  end

  // Response fields only change on the edge entering RESP, so they hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      sel_idx   <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_we      <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        s_addr  <= req_addr;
        s_wdata <= req_wdata;
        s_we    <= req_we;
        sel_idx <= dec_idx;
        if (!dec_hit) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
      if (state == ST_ACCESS) begin
        if (sel_ready) begin
          rsp_err   <= 1'b0;
          rsp_rdata <= s_we ? '0 : s_rdata[sel_idx*DATA_W +: DATA_W];
        end else if (tmo_hit) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
    end
  end

endmodule

// File: doc/mmio_interconnect.md
MMIO_INTERCONNECT -- requirements
Module: mmio_interconnect

Interface
REQ-001 Parameter NUM_SLAVES, default 4: number of memory-mapped slave channels, 1..16.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width.
REQ-004 Parameter REGION_BASE, default {0x0000_0000,0x0000_1000,0x0000_2000,0x0000_3000}: per-slave base address, packed array of ADDR_W entries.
REQ-005 Parameter REGION_MASK, default {0xFFFF_F000 x4}: per-slave compare mask; slave k hits when (addr & MASK[k]) == BASE[k].
REQ-006 Parameter TIMEOUT_CYCLES, default 16: maximum ACCESS-state wait before error, 2..255.
REQ-007 Ports, one per line:
  clk  in  1  single clock, all logic on rising edge
  reset  in  1  synchronous, active-high reset
  req_valid  in  1  CPU access request
  req_ready  out  1  interconnect can accept a request
  req_addr  in  ADDR_W  access address
  req_wdata  in  DATA_W  write data
  req_we  in  1  1=write, 0=read
  rsp_valid  out  1  one-cycle completion pulse
  rsp_rdata  out  DATA_W  read data, valid with rsp_valid
  rsp_err  out  1  decode miss or timeout, valid with rsp_valid
  s_sel  out  NUM_SLAVES  one-hot slave select
  s_addr  out  ADDR_W  registered address to slaves
  s_wdata  out  DATA_W  registered write data to slaves
  s_we  out  1  registered write enable, qualified by s_sel
  s_ready  in  NUM_SLAVES  per-slave completion
  s_rdata  in  NUM_SLAVES*DATA_W  per-slave read data, slave k at bits [k*DATA_W +: DATA_W]

Function
REQ-008 FSM states IDLE, ACCESS, RESP; the state SHALL be registered.
REQ-009 In IDLE, req_ready SHALL be 1; it SHALL be 0 in ACCESS and RESP.
REQ-010 A request is accepted at the edge where req_valid&&req_ready; addr/wdata/we SHALL be latched into s_addr/s_wdata/s_we.
REQ-011 Decode at acceptance: on any hit go to ACCESS with the slave index latched; on a miss go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-012 Multiple hits: the lowest slave index SHALL win.
REQ-013 In ACCESS, s_sel SHALL be one-hot for the latched slave; s_sel SHALL be 0 in all other states.
REQ-014 In ACCESS, s_ready[k] for the selected k SHALL capture s_rdata[k] (reads only; writes capture 0) and go to RESP; s_ready of unselected slaves SHALL be ignored.
REQ-015 Minimum latency: acceptance at edge T, s_sel high in cycle T+1, rsp_valid high in cycle T+2 if s_ready is high in T+1.
REQ-016 In RESP, rsp_valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; back-to-back requests SHALL be spaced at least 3 cycles apart.
REQ-017 rsp_rdata and rsp_err SHALL hold their last values when rsp_valid is 0.
REQ-018 req_valid in non-IDLE states SHALL be ignored and not queued.

Reset
REQ-019 Reset SHALL force IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; s_sel=0; s_we=0; s_addr=0; s_wdata=0; timeout counter=0.
REQ-020 Reset asserted during ACCESS or RESP SHALL abort the transaction with no rsp_valid pulse.

Configuration
REQ-021 Macro MMIO_TIMEOUT_EN: when defined, an 8-bit counter SHALL clear on entry to ACCESS and increment each ACCESS cycle; reaching TIMEOUT_CYCLES without s_ready SHALL go to RESP with rsp_err=1, rsp_rdata=0.
REQ-022 Without MMIO_TIMEOUT_EN, no counter SHALL exist and ACCESS SHALL wait indefinitely for s_ready.

Structure
REQ-023 Package mmio_pkg SHALL hold the FSM state enum and default region base/mask constants.
REQ-024 Sub-module mmio_region_decoder SHALL implement the combinational priority address match, outputting hit and index.

Verification
REQ-025 Read 0x0000_1004, s_ready[1] high at T+1 with rdata 0xDEADBEEF -> s_sel=4'b0010 at T+1; rsp_valid, rsp_rdata=0xDEADBEEF, rsp_err=0 at T+2.
REQ-026 Write 0x0000_3010 data 0x55 -> s_we=1, s_wdata=0x55, s_sel=4'b1000; rsp_err=0, rsp_rdata=0.
REQ-027 Access 0x0000_8000 (no hit) -> no s_sel, rsp_valid at T+1 with rsp_err=1, rsp_rdata=0.
REQ-028 MMIO_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave 2 never ready -> rsp_err=1 after 16 ACCESS cycles.
REQ-029 Reset pulsed in ACCESS -> next cycle IDLE, req_ready=1, no rsp_valid.
REQ-030 Overlapping regions 0 and 1 matching 0x0000_0000 -> s_sel=4'b0001.
